lcd_spi_sink: RTL and testbench

- Panel-side receiver for the 4-wire ST7789V3 SPI write interface (CS, SCK, SD, RS/DC, RST).
- Samples the LCD pins with the system clock, deserializes bytes MSB-first, and tags each byte as command or data.
- Buffers received bytes in a small FIFO with a valid/ready output stream.
- Used as a loopback checker and panel model: the on-chip LCD driver's pins feed it, so the driver's command/data stream can be inspected on hardware and in simulation.

---
 rtl/lcd_spi_sink.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_spi_sink.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_sink.sv
// ST7789V3 4-wire SPI panel-side receiver: oversampled pins, MSB-first bytes tagged command/data, buffered in a small FIFO.
// Latency: pin SCK edge to out_valid is SYNC_STAGES+2 clk cycles with the FIFO empty. Backpressure: out_valid/out_ready; a byte arriving while full is dropped and sets overflow.
// Optional LCD_SPI_SINK_PIXCNT_EN adds pix_count/in_ramwr pixel tracking of RAMWR (0x2C) data.
module lcd_spi_sink #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_cs,
    input  logic       lcd_sck,
    input  logic       lcd_sd,
    input  logic       lcd_rs,
    input  logic       lcd_rst,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_dc,
    output logic       overflow,
    output logic       frame_err
`ifdef LCD_SPI_SINK_PIXCNT_EN
    ,
    output logic [15:0] pix_count,
    output logic        in_ramwr
`endif
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sd_sync, rs_sync, prst_sync;
    logic cs_prev, sck_prev;
    logic cs_s, sck_s, sd_s, rs_s, prst_s, sck_rise, cs_rise;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sd_s     = sd_sync[SYNC_STAGES-1];
    assign rs_s     = rs_sync[SYNC_STAGES-1];
    assign prst_s   = prst_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            sd_sync   <= '0;
            rs_sync   <= '0;
            prst_sync <= '1;
            cs_prev   <= 1'b1;
            sck_prev  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], lcd_cs};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], lcd_sck};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], lcd_sd};
            rs_sync   <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
            prst_sync <= {prst_sync[SYNC_STAGES-2:0], lcd_rst};
            cs_prev   <= cs_s;
            sck_prev  <= sck_s;
        end
    end

    state_t     state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       push, ferr_nxt;
    logic [8:0] push_dat;

    assign push_dat = {rs_s, shreg[6:0], sd_s};

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        push        = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_nxt = 3'd0;
                if (!cs_s) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (sck_rise) begin
                    shreg_nxt   = {shreg[6:0], sd_s};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    push        = (bit_cnt == 3'd7);
                end
                // The bit on a coincident SCK edge counts before judging the CS edge.
                if (cs_rise) begin
                    state_nxt   = IDLE;
                    ferr_nxt    = (bit_cnt_nxt != 3'd0);
                    bit_cnt_nxt = 3'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!prst_s) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = 3'd0;
            push        = 1'b0;
            ferr_nxt    = 1'b0;
        end
    end

    logic       stg_vld;
    logic [8:0] stg_dat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            frame_err <= 1'b0;
            stg_vld   <= 1'b0;
            stg_dat   <= 9'd0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            frame_err <= ferr_nxt;
            stg_vld   <= push;
            if (push) stg_dat <= push_dat;
        end
    end

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AW:0]   count, count_nxt;
    logic          pop, full, wr_en, drop;
    logic [8:0]    head_nxt;

    always_comb begin
        pop        = out_valid & out_ready & prst_s;
        full       = (count == (AW+1)'(FIFO_DEPTH));
        wr_en      = stg_vld & prst_s & (~full | pop);
        drop       = stg_vld & prst_s & full & ~pop;
        rd_ptr_nxt = rd_ptr + AW'(pop);
        count_nxt  = count + (AW+1)'(wr_en) - (AW+1)'(pop);
        // Head slot being written this cycle bypasses the memory read.
        head_nxt   = (wr_en && (rd_ptr_nxt == wr_ptr)) ? stg_dat : mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= stg_dat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_dc    <= 1'b0;
            overflow  <= 1'b0;
        end else if (!prst_s) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (count_nxt != '0) {out_dc, out_data} <= head_nxt;
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef LCD_SPI_SINK_PIXCNT_EN
    logic data_odd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_count <= 16'd0;
            in_ramwr  <= 1'b0;
            data_odd  <= 1'b0;
        end else if (!prst_s) begin
            pix_count <= 16'd0;
            in_ramwr  <= 1'b0;
            data_odd  <= 1'b0;
        end else if (push) begin
            if (!push_dat[8]) begin
                in_ramwr <= (push_dat[7:0] == 8'h2C);
                if (push_dat[7:0] == 8'h2C) begin
                    pix_count <= 16'd0;
                    data_odd  <= 1'b0;
                end
            end else if (in_ramwr) begin
                // Two data bytes per RGB565 pixel.
                data_odd <= ~data_odd;
                if (data_odd) pix_count <= pix_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lcd_spi_sink.sv
// Bench for lcd_spi_sink: SPI pin driver, queue-based reference model and a decoupled output monitor.
`timescale 1ns/1ps
module tb_lcd_spi_sink;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, lcd_cs, lcd_sck, lcd_sd, lcd_rs, lcd_rst, out_ready;
    logic       out_valid, out_dc, overflow, frame_err;
    logic [7:0] out_data;
`ifdef LCD_SPI_SINK_PIXCNT_EN
    logic [15:0] pix_count;
    logic        in_ramwr;
`endif

    lcd_spi_sink #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .lcd_cs(lcd_cs), .lcd_sck(lcd_sck), .lcd_sd(lcd_sd),
        .lcd_rs(lcd_rs), .lcd_rst(lcd_rst), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dc(out_dc), .overflow(overflow), .frame_err(frame_err)
`ifdef LCD_SPI_SINK_PIXCNT_EN
        , .pix_count(pix_count), .in_ramwr(in_ramwr)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;
    bit         exp_ovf = 1'b0;
    int         exp_ferr = 0;
    int         ferr_cycles = 0;
    int         ready_pct = 0;
    int         data_since = 0;
    bit         exp_ramwr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a bounded queue of {dc,byte}; a byte finding it full is lost.
    task automatic model_byte(input logic [7:0] b, input logic rs);
        if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back({rs, b});
        if (!rs) begin
            exp_ramwr = (b == 8'h2C);
            if (b == 8'h2C) data_since = 0;
        end else if (exp_ramwr) begin
            data_since++;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic rs, input int nbits, input bit lat);
        for (int i = 7; i > 7 - nbits; i--) begin
            lcd_sd = b[i];
            lcd_rs = rs;
            repeat (4) @(negedge clk);
            lcd_sck = 1'b1;
            if (i == 0) model_byte(b, rs);
            if (lat && i == 0) begin
                repeat (3) @(negedge clk);
                check("latency_3cyc_not_yet", 32'(out_valid), 0);
                @(negedge clk);
                check("latency_4cyc_valid", 32'(out_valid), 1);
            end else begin
                repeat (4) @(negedge clk);
            end
            lcd_sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        lcd_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clk);
        lcd_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 0);
    endtask

    // Monitor: owns out_ready, pops the scoreboard on every accepted entry.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) ferr_cycles++;
            out_ready = (int'($urandom_range(99)) < ready_pct);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no entry", {out_dc, out_data});
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_entry", 32'({out_dc, out_data}), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        logic [7:0] t2 [3];
        logic [7:0] b;
        logic       rs;
        int         nb;
        t2 = '{8'h00, 8'h01, 8'hEF};
        rst = 1'b0; lcd_cs = 1'b1; lcd_sck = 1'b0; lcd_sd = 1'b0; lcd_rs = 1'b0; lcd_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_dc", 32'(out_dc), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        ready_pct = 100;
        cs_begin(); send_bits(8'h2A, 1'b0, 8, 1'b1); cs_end();
        wait_drain();
        check("no_frame_err_single", 32'(ferr_cycles), 0);

        cs_begin();
        for (int i = 0; i < 3; i++) send_bits(t2[i], 1'b1, 8, 1'b0);
        cs_end();
        wait_drain();

        ready_pct = 0;
        cs_begin();
        for (int i = 0; i < 6; i++) send_bits(8'h10 + 8'(i), 1'b1, 8, 1'b0);
        cs_end();
        check("overflow_set", 32'(overflow), 32'(exp_ovf));
        check("full_valid", 32'(out_valid), 1);
        ready_pct = 100;
        wait_drain();
        check("overflow_sticky", 32'(overflow), 32'(exp_ovf));

        cs_begin(); send_bits(8'hA5, 1'b0, 5, 1'b0); cs_end();
        exp_ferr++;
        check("frame_err_one_cycle", 32'(ferr_cycles), 32'(exp_ferr));
        check("frame_err_fifo_empty", 32'(out_valid), 0);
        cs_begin(); send_bits(8'h5A, 1'b1, 8, 1'b0); cs_end();
        wait_drain();

        ready_pct = 0;
        cs_begin(); send_bits(8'h33, 1'b1, 8, 1'b0); send_bits(8'h44, 1'b0, 8, 1'b0); cs_end();
        check("queued_before_prst", 32'(out_valid), 1);
        lcd_rst = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.delete(); exp_ovf = 1'b0; data_since = 0; exp_ramwr = 1'b0;
        check("prst_flush", 32'(out_valid), 0);
        check("prst_overflow_clear", 32'(overflow), 32'(exp_ovf));
        lcd_rst = 1'b1;
        repeat (5) @(negedge clk);
        ready_pct = 100;
        cs_begin(); send_bits(8'hC3, 1'b0, 8, 1'b0); cs_end();
        wait_drain();

`ifdef LCD_SPI_SINK_PIXCNT_EN
        cs_begin();
        send_bits(8'h2C, 1'b0, 8, 1'b0);
        for (int i = 0; i < 6; i++) send_bits(8'($urandom), 1'b1, 8, 1'b0);
        cs_end();
        check("pix_count_after_ramwr", 32'(pix_count), 32'((data_since / 2) % 65536));
        check("in_ramwr_set", 32'(in_ramwr), 32'(exp_ramwr));
        cs_begin(); send_bits(8'h29, 1'b0, 8, 1'b0); cs_end();
        check("in_ramwr_cleared", 32'(in_ramwr), 32'(exp_ramwr));
        check("pix_count_holds", 32'(pix_count), 32'((data_since / 2) % 65536));
        wait_drain();
`endif

        ready_pct = 50;
        for (int w = 0; w < 16; w++) begin
            nb = int'($urandom_range(1, 4));
            cs_begin();
            for (int i = 0; i < nb; i++) begin
                rs = 1'($urandom);
                b  = ($urandom_range(3) == 0) ? 8'h2C : 8'($urandom);
                send_bits(b, rs, 8, 1'b0);
            end
            if ($urandom_range(3) == 0) begin
                send_bits(8'($urandom), 1'b1, int'($urandom_range(1, 7)), 1'b0);
                exp_ferr++;
            end
            cs_end();
        end
        ready_pct = 100;
        wait_drain();
        check("final_overflow", 32'(overflow), 32'(exp_ovf));
        check("final_frame_err_count", 32'(ferr_cycles), 32'(exp_ferr));
`ifdef LCD_SPI_SINK_PIXCNT_EN
        check("final_pix_count", 32'(pix_count), 32'((data_since / 2) % 65536));
        check("final_in_ramwr", 32'(in_ramwr), 32'(exp_ramwr));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
